fifo_axis_reader: RTL
=====================

// Module: fifo_axis_reader
// PURPOSE
//  Read-side master for the BRAM-backed sync FIFO (registered dout, 1-cycle read latency).
//  Drains the FIFO through rd_en/dout/empty and presents the data as an AXI4-Stream master.
//  Full throughput (1 beat/clk) under continuous tready. Optional tlast every PKT_LEN beats.
//  Sits between any FIFO consumer port and downstream AXIS logic (DMA, DAC/ADC stream muxes).
// PARAMETERS
//  B        16  data width; must equal the FIFO data width
//  PKT_LEN  0   beats per packet; 0 = tlast tied 0; range 1..65535 otherwise
// PORTS
//  clk            in   1  single clock, shared with the FIFO
//  rst            in   1  asynchronous, active-high reset
//  fifo_rd_en     out  1  read strobe to the FIFO
//  fifo_dout      in   B  FIFO read data, valid on the cycle after an accepted rd_en
//  fifo_empty     in   1  FIFO empty flag
//  m_axis_tdata   out  B  stream data = skid buffer head
//  m_axis_tvalid  out  1  skid buffer non-empty
//  m_axis_tready  in   1  downstream accept
//  m_axis_tlast   out  1  last beat of a PKT_LEN packet
// BEHAVIOUR
//  - Reset (async assert, sync release): occ=0, inflight=0, beat_cnt=0.
//    Outputs: tvalid=0, tlast=0, fifo_rd_en=0. tdata is don't-care.
//  - Skid buffer: 3 entries (SKID_DEPTH), with occ (0..3) and a 1-bit inflight flag.
//  - fifo_rd_en = !fifo_empty && (occ + inflight < 3). Combinational from registered
//    state and fifo_empty only. No path from m_axis_tready.
//  - Never assert fifo_rd_en while fifo_empty=1. The FIFO BRAM would still read, but
//    its pointer would not move, and a stale word would enter the stream.
//  - inflight <= fifo_rd_en on every clk.
//    When inflight=1, push fifo_dout into the skid buffer tail on that edge.
//  - pop = tvalid && tready. Remove the head on that edge.
//    Push and pop in the same cycle: occ unchanged, FIFO order preserved.
//  - Latency: rd_en at cycle N -> fifo_dout at N+1 -> tvalid at N+2.
//    Steady state (occ=1, inflight=1, tready=1) gives 1 beat/clk.
//  - Backpressure: with tready=0, at most 3 words are pulled; rd_en then stays low.
//    tdata/tvalid/tlast hold stable until accepted (AXIS rule). No loss or duplication.
//  - tlast (PKT_LEN>0):
//    - tlast = (beat_cnt == PKT_LEN-1) && tvalid.
//    - On pop, beat_cnt increments and wraps to 0 after PKT_LEN-1.
//    - beat_cnt is 16 bits.
//  - Overflow is impossible by construction (occ+inflight<=3). Flag occ>3 with an
//    assertion in simulation.
//  - Reset mid-operation clears the buffer, any in-flight word and beat_cnt. Data already
//    pulled from the FIFO is lost. FIFO pointer reset is owned by the FIFO's own rstn.
// STRUCTURE
//  - Package fifo_axis_reader_pkg:
//    - localparam SKID_DEPTH = 3
//    - typedef logic [1:0] occ_t (occupancy, 0..3)
//    - typedef logic [15:0] beat_cnt_t
//  - Sub-module skid_fifo_reg #(B, SKID_DEPTH):
//    - register-array FIFO: push, pop, head, occ; async active-high reset
//    - no BRAM
//  - Top level holds the rd_en issue logic, the inflight flop and the tlast beat counter.
// TESTING
//  1 rst=1 with arbitrary inputs -> tvalid=0, tlast=0, fifo_rd_en=0. Hold after release with fifo_empty=1.
//  2 FIFO preloaded 0x0001..0x0008, tready=1 -> rd_en at cycle 0, first tvalid at cycle 2,
//    8 consecutive beats 0x0001..0x0008, then tvalid=0.
//  3 Same preload, tready=0 for 20 clk -> exactly 3 rd_en pulses, tdata=0x0001 held.
//    Release tready -> 0x0001..0x0008 in order, no gaps after the first beat.
//  4 PKT_LEN=4, 8 words, tready toggling 1/0 per clk -> tlast only on 0x0004 and 0x0008.
//    tdata/tlast stable while tready=0.
//  5 fifo_empty asserted mid-stream after 0x0003, 5 idle clk, then 0x0004 written ->
//    rd_en never high while empty; stream 0x0001..0x0004 with no stale or duplicate beat.
//  6 rst pulsed while occ=2 and inflight=1 -> tvalid=0 next cycle.
//    After release, first beat is the next FIFO word; none of the 3 discarded words reappear.

Source files
------------

// File: rtl/fifo_axis_reader_pkg.sv
// Shared types and sizing for the FIFO-to-AXIS reader.
// Skid depth covers the one-word BRAM read latency plus backpressure slack.
package fifo_axis_reader_pkg;

  localparam int SKID_DEPTH = 3;

  typedef logic [1:0]  occ_t;
  typedef logic [15:0] beat_cnt_t;

endpackage

// File: rtl/fifo_axis_reader_skid.sv
// Small register-array FIFO that absorbs words already requested from the BRAM FIFO.
// Head is combinational from the array; occupancy is registered.
module skid_fifo_reg
  import fifo_axis_reader_pkg::*;
#(
  parameter int B     = 16,
  parameter int DEPTH = SKID_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [B-1:0] data_i,
  input  logic         pop_i,
  output logic [B-1:0] head_o,
  output occ_t         occ_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PW-1:0] ptr_t;

  logic [B-1:0] mem_q [DEPTH];
  ptr_t         wr_q, wr_d;
  ptr_t         rd_q, rd_d;
  occ_t         occ_q, occ_d;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Next pointers and occupancy; push and pop together leave occ unchanged.
  always_comb begin
    wr_d  = push_i ? ptr_inc(wr_q) : wr_q;
    rd_d  = pop_i  ? ptr_inc(rd_q) : rd_q;
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + occ_t'(1);
      2'b01:   occ_d = occ_q - occ_t'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  // Data storage needs no reset; occupancy gates its visibility.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign head_o = mem_q[rd_q];
  assign occ_o  = occ_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && occ_q == occ_t'(DEPTH)));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop_i && occ_q == '0));

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a registered-output sync FIFO and presents it as an AXI4-Stream master.
// Reads are issued only when the skid buffer can hold every outstanding word.
module fifo_axis_reader
  import fifo_axis_reader_pkg::*;
#(
  parameter int B       = 16,
  parameter int PKT_LEN = 0
) (
  input  logic         clk,
  input  logic         rst,
  output logic         fifo_rd_en,
  input  logic [B-1:0] fifo_dout,
  input  logic         fifo_empty,
  output logic [B-1:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast
);

  localparam beat_cnt_t LAST_BEAT =
    (PKT_LEN > 0) ? beat_cnt_t'(PKT_LEN - 1) : '0;

  logic      inflight_q, inflight_d;
  beat_cnt_t beat_q, beat_d;
  occ_t      occ;
  logic      pop;
  logic [2:0] pending;

  assign pending    = {1'b0, occ} + {2'b00, inflight_q};
  assign fifo_rd_en = !rst && !fifo_empty &&
                      (pending < 3'(SKID_DEPTH));

  assign m_axis_tvalid = (occ != '0);
  assign pop           = m_axis_tvalid && m_axis_tready;

  skid_fifo_reg #(
    .B     (B),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .push_i (inflight_q),
    .data_i (fifo_dout),
    .pop_i  (pop),
    .head_o (m_axis_tdata),
    .occ_o  (occ)
  );

  // Next in-flight flag and packet beat position.
  always_comb begin
    inflight_d = fifo_rd_en;
    beat_d     = beat_q;
    if (pop) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + beat_cnt_t'(1);
    end
  end

  // In-flight flag and beat counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
    end
  end

  assign m_axis_tlast = (PKT_LEN > 0) && m_axis_tvalid &&
                        (beat_q == LAST_BEAT);

endmodule
